// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the
// EXE/MEM pipeline register. Redirect and target are combinational so the
// fetch stage can act in the same cycle the branch is resolved.
module exe_stage (
    input  logic         clk,
    input  logic         clr,
    input  logic [162:0] in,
    input  logic         stall,
    input  logic         flush,
    input  logic         mem_regwrite,
    input  logic [4:0]   mem_rd,
    input  logic [31:0]  mem_alu,
    input  logic         wb_regwrite,
    input  logic [4:0]   wb_rd,
    input  logic [31:0]  wb_data,
    output logic [71:0]  out,
    output logic         redirect,
    output logic [31:0]  target
);

    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        branch_eq;
    logic        jump;
    logic        alusrc;
    logic        regdst;
    logic [2:0]  aluc;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] pc4;
    logic [25:0] adr;
    logic [4:0]  rs;

    assign regwrite  = in[0];
    assign memtoreg  = in[1];
    assign memwrite  = in[2];
    assign branch_eq = in[3];
    assign jump      = in[4];
    assign alusrc    = in[5];
    assign regdst    = in[6];
    assign aluc      = in[9:7];
    assign rt        = in[14:10];
    assign rd        = in[19:15];
    assign imm       = in[35:20];
    assign qa        = in[67:36];
    assign qb        = in[99:68];
    assign pc4       = in[131:100];
    assign adr       = in[157:132];
    assign rs        = in[162:158];

    logic [31:0] op_a;
    logic [31:0] op_bf;
    logic [31:0] simm;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic [4:0]  write_reg;
    logic        branch_taken;

    assign simm      = {{16{imm[15]}}, imm};
    assign write_reg = regdst ? rd : rt;

    // Forwarding: MEM holds the newer value so it beats WB; $0 never forwards.
    always_comb begin
        op_a = qa;
        if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rs))
            op_a = mem_alu;
        else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs))
            op_a = wb_data;

        op_bf = qb;
        if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rt))
            op_bf = mem_alu;
        else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rt))
            op_bf = wb_data;
    end

    // ALU: add/sub wrap silently, slt is a signed compare, 110 is a lui-style shift.
    always_comb begin
        alu_b = alusrc ? simm : op_bf;
        case (aluc)
            3'b000:  alu_res = op_a + alu_b;
            3'b001:  alu_res = op_a - alu_b;
            3'b010:  alu_res = op_a & alu_b;
            3'b011:  alu_res = op_a | alu_b;
            3'b100:  alu_res = op_a ^ alu_b;
            3'b101:  alu_res = ($signed(op_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            3'b110:  alu_res = {alu_b[15:0], 16'h0000};
            default: alu_res = ~(op_a | alu_b);
        endcase
    end

    // Branch compares forwarded operands regardless of ALUSrc; jump wins over branch.
    always_comb begin
        branch_taken = branch_eq && (op_a == op_bf);
        redirect     = (branch_taken || jump) && !stall && !clr;
        target       = 32'd0;
        if (redirect) begin
            if (jump)
                target = {pc4[31:28], adr, 2'b00};
            else
                target = pc4 + {simm[29:0], 2'b00};
        end
    end

    // EXE/MEM register: clear beats flush beats stall beats load.
    always_ff @(posedge clk) begin
        if (clr || flush)
            out <= '0;
        else if (!stall)
            out <= {op_bf, alu_res, write_reg, memwrite, memtoreg, regwrite};
    end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios plus a randomized run
// compared against a behavioural model of the execute stage.
module tb_exe_stage;

    logic         clk;
    logic         clr;
    logic         stall;
    logic         flush;
    logic         mem_regwrite;
    logic [4:0]   mem_rd;
    logic [31:0]  mem_alu;
    logic         wb_regwrite;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_data;
    logic [71:0]  out;
    logic         redirect;
    logic [31:0]  target;
    logic [162:0] in_bus;

    logic         f_regwrite, f_memtoreg, f_memwrite, f_beq, f_jump, f_alusrc, f_regdst;
    logic [2:0]   f_aluc;
    logic [4:0]   f_rt, f_rd, f_rs;
    logic [15:0]  f_imm;
    logic [31:0]  f_qa, f_qb, f_pc4;
    logic [25:0]  f_adr;

    int n_cmp;
    int n_err;

    assign in_bus = {f_rs, f_adr, f_pc4, f_qb, f_qa, f_imm, f_rd, f_rt, f_aluc,
                     f_regdst, f_alusrc, f_jump, f_beq, f_memwrite, f_memtoreg, f_regwrite};

    exe_stage dut (
        .clk          (clk),
        .clr          (clr),
        .in           (in_bus),
        .stall        (stall),
        .flush        (flush),
        .mem_regwrite (mem_regwrite),
        .mem_rd       (mem_rd),
        .mem_alu      (mem_alu),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .out          (out),
        .redirect     (redirect),
        .target       (target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // A register read sees the newest in-flight producer: apply WB, then let MEM overwrite.
    function automatic logic [31:0] fwd_value(input logic [4:0] src, input logic [31:0] reg_val);
        logic [31:0] v;
        v = reg_val;
        if (src != 5'd0 && wb_regwrite && wb_rd == src) v = wb_data;
        if (src != 5'd0 && mem_regwrite && mem_rd == src) v = mem_alu;
        return v;
    endfunction

    function automatic logic [31:0] sext_imm();
        int s;
        s = int'($signed(f_imm));
        return 32'(s);
    endfunction

    function automatic logic [71:0] model_out();
        logic [31:0] a, bf, b, res;
        a  = fwd_value(f_rs, f_qa);
        bf = fwd_value(f_rt, f_qb);
        b  = f_alusrc ? sext_imm() : bf;
        case (f_aluc)
            3'd0: res = a + b;
            3'd1: res = a - b;
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd6: res = b * 32'd65536;
            default: res = ~(a | b);
        endcase
        return {bf, res, (f_regdst ? f_rd : f_rt), f_memwrite, f_memtoreg, f_regwrite};
    endfunction

    function automatic logic model_redirect();
        logic taken;
        taken = f_jump || (f_beq && (fwd_value(f_rs, f_qa) == fwd_value(f_rt, f_qb)));
        return taken && !stall && !clr;
    endfunction

    function automatic logic [31:0] model_target();
        if (!model_redirect()) return 32'd0;
        if (f_jump) return {f_pc4[31:28], f_adr, 2'b00};
        return f_pc4 + sext_imm() * 32'd4;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fields();
        {f_regwrite, f_memtoreg, f_memwrite, f_beq, f_jump, f_alusrc, f_regdst} = 7'd0;
        f_aluc = 3'd0; f_rt = 5'd0; f_rd = 5'd0; f_rs = 5'd0; f_imm = 16'd0;
        f_qa = 32'd0; f_qb = 32'd0; f_pc4 = 32'd0; f_adr = 26'd0;
        mem_regwrite = 1'b0; mem_rd = 5'd0; mem_alu = 32'd0;
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    endtask

    task automatic rand_fields();
        logic [31:0] r;
        r = $urandom;
        {f_regwrite, f_memtoreg, f_memwrite, f_beq, f_alusrc, f_regdst} = r[5:0];
        f_jump = (r[9:6] == 4'd0);
        f_aluc = r[12:10];
        f_rt = r[17:13]; f_rd = r[22:18]; f_rs = r[27:23];
        r = $urandom; f_imm = r[15:0]; f_adr = {r[31:16], r[9:0]};
        f_qa = $urandom; f_qb = $urandom; f_pc4 = $urandom;
        r = $urandom;
        if (r[0]) f_qb = f_qa;
        if (r[1]) f_qa = {{28{r[2]}}, r[6:3]};
    endtask

    task automatic rand_fwd();
        logic [31:0] r;
        r = $urandom;
        mem_regwrite = r[0];
        wb_regwrite  = r[1];
        mem_rd = (r[3:2] == 2'd0) ? f_rs : (r[3:2] == 2'd1) ? f_rt : r[8:4];
        wb_rd  = (r[10:9] == 2'd0) ? f_rs : (r[10:9] == 2'd1) ? f_rt : r[15:11];
        mem_alu = $urandom;
        wb_data = $urandom;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [71:0] exp;
        rand_fields(); rand_fwd();
        f_jump = 1'b1;
        clr = 1'b1; stall = 1'b0; flush = 1'b0;
        #1;
        n_cmp++;
        if (redirect !== 1'b0 || target !== 32'd0) begin
            n_err++; $display("FAIL reset_redirect: got %b/%h expected 0/00000000", redirect, target);
        end
        tick(); tick();
        n_cmp++;
        if (out !== 72'd0) begin n_err++; $display("FAIL reset_out: got %h expected 0", out); end
        // first edge after release loads normally
        clr = 1'b0; f_jump = 1'b0;
        exp = model_out();
        tick();
        n_cmp++;
        if (out !== exp) begin n_err++; $display("FAIL reset_release_load: got %h expected %h", out, exp); end
        // clear wins over stall
        rand_fields();
        clr = 1'b1; stall = 1'b1;
        tick();
        n_cmp++;
        if (out !== 72'd0) begin n_err++; $display("FAIL reset_over_stall: got %h expected 0", out); end
        clr = 1'b0; stall = 1'b0;
    endtask

    task automatic test_sub();
        clear_fields();
        f_qa = 32'd5; f_qb = 32'd3; f_aluc = 3'b001; f_regdst = 1'b1; f_rd = 5'd7; f_regwrite = 1'b1;
        tick();
        n_cmp++;
        if (out[39:8] !== 32'd2 || out[7:3] !== 5'd7 || out[0] !== 1'b1 || out[71:40] !== 32'd3) begin
            n_err++; $display("FAIL sub_basic: got %h expected alu=2 wr=7 rw=1 st=3", out);
        end
    endtask

    task automatic test_forwarding();
        clear_fields();
        f_rs = 5'd4; f_qa = 32'd1; f_imm = 16'd1; f_alusrc = 1'b1;
        mem_regwrite = 1'b1; mem_rd = 5'd4; mem_alu = 32'h10;
        wb_regwrite = 1'b1; wb_rd = 5'd4; wb_data = 32'h20;
        tick();
        n_cmp++;
        if (out[39:8] !== 32'h11) begin n_err++; $display("FAIL fwd_mem_priority: got %h expected 00000011", out[39:8]); end
        mem_regwrite = 1'b0;
        tick();
        n_cmp++;
        if (out[39:8] !== 32'h21) begin n_err++; $display("FAIL fwd_wb: got %h expected 00000021", out[39:8]); end
        mem_regwrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; f_rs = 5'd0;
        tick();
        n_cmp++;
        if (out[39:8] !== 32'h2) begin n_err++; $display("FAIL fwd_zero_reg: got %h expected 00000002", out[39:8]); end
        // store data takes forwarded Rt
        f_rt = 5'd9; f_qb = 32'h55; mem_rd = 5'd9; mem_alu = 32'hCAFE0001;
        tick();
        n_cmp++;
        if (out[71:40] !== 32'hCAFE0001) begin n_err++; $display("FAIL fwd_store_data: got %h expected cafe0001", out[71:40]); end
    endtask

    task automatic test_branch();
        clear_fields();
        f_beq = 1'b1; f_qa = 32'd9; f_qb = 32'd9; f_pc4 = 32'h100; f_imm = 16'hFFFF;
        #1;
        n_cmp++;
        if (redirect !== 1'b1 || target !== 32'hFC) begin
            n_err++; $display("FAIL branch_taken: got %b/%h expected 1/000000fc", redirect, target);
        end
        f_qb = 32'd8;
        #1;
        n_cmp++;
        if (redirect !== 1'b0 || target !== 32'd0) begin
            n_err++; $display("FAIL branch_not_taken: got %b/%h expected 0/00000000", redirect, target);
        end
        // ALUSrc must not affect the compare; forwarded Rt makes them equal
        f_alusrc = 1'b1; f_imm = 16'h0004; f_rt = 5'd3;
        mem_regwrite = 1'b1; mem_rd = 5'd3; mem_alu = 32'd9;
        #1;
        n_cmp++;
        if (redirect !== 1'b1 || target !== 32'h110) begin
            n_err++; $display("FAIL branch_fwd_alusrc: got %b/%h expected 1/00000110", redirect, target);
        end
        tick();
    endtask

    task automatic test_jump_stall();
        logic [71:0] held;
        clear_fields();
        f_jump = 1'b1; f_beq = 1'b1; f_pc4 = 32'hA0000004; f_adr = 26'h0000010; f_imm = 16'h0008;
        #1;
        n_cmp++;
        if (redirect !== 1'b1 || target !== 32'hA0000040) begin
            n_err++; $display("FAIL jump_target: got %b/%h expected 1/a0000040", redirect, target);
        end
        rand_fields(); rand_fwd();
        held = model_out();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_fields(); rand_fwd();
            f_jump = 1'b1;
            #1;
            n_cmp++;
            if (redirect !== 1'b0 || target !== 32'd0) begin
                n_err++; $display("FAIL stall_redirect: got %b/%h expected 0/00000000", redirect, target);
            end
            tick();
            n_cmp++;
            if (out !== held) begin n_err++; $display("FAIL stall_hold: got %h expected %h", out, held); end
        end
        stall = 1'b0;
    endtask

    task automatic test_priority();
        logic [71:0] exp;
        rand_fields(); rand_fwd();
        f_regwrite = 1'b1;
        clr = 1'b1; flush = 1'b1; stall = 1'b1;
        tick();
        n_cmp++;
        if (out !== 72'd0) begin n_err++; $display("FAIL prio_all_high: got %h expected 0", out); end
        clr = 1'b0; flush = 1'b0; stall = 1'b0;
        exp = model_out();
        tick();
        n_cmp++;
        if (out !== exp) begin n_err++; $display("FAIL prio_load: got %h expected %h", out, exp); end
        flush = 1'b1;
        tick();
        n_cmp++;
        if (out !== 72'd0) begin n_err++; $display("FAIL prio_flush: got %h expected 0", out); end
        flush = 1'b0;
        exp = model_out();
        tick();
        flush = 1'b1; stall = 1'b1;
        tick();
        n_cmp++;
        if (out !== 72'd0) begin n_err++; $display("FAIL prio_flush_over_stall: got %h expected 0", out); end
        flush = 1'b0; stall = 1'b0;
        exp = model_out();
        tick();
        n_cmp++;
        if (out !== exp) begin n_err++; $display("FAIL prio_reload: got %h expected %h", out, exp); end
    endtask

    task automatic test_bubble();
        clear_fields();
        rand_fwd();
        #1;
        n_cmp++;
        if (redirect !== 1'b0 || target !== 32'd0) begin
            n_err++; $display("FAIL bubble_redirect: got %b/%h expected 0/00000000", redirect, target);
        end
        tick();
        n_cmp++;
        if (out !== 72'd0) begin n_err++; $display("FAIL bubble_out: got %h expected 0", out); end
    endtask

    task automatic test_random();
        logic [71:0] exp_out;
        logic [31:0] r;
        clr = 1'b1;
        tick();
        exp_out = 72'd0;
        for (int i = 0; i < 400; i++) begin
            rand_fields(); rand_fwd();
            r = $urandom;
            clr   = (r[4:0] == 5'd0);
            flush = (r[8:5] == 4'd0);
            stall = (r[11:9] == 3'd0);
            #1;
            n_cmp++;
            if (redirect !== model_redirect() || target !== model_target()) begin
                n_err++; $display("FAIL rand_redirect[%0d]: got %b/%h expected %b/%h",
                                  i, redirect, target, model_redirect(), model_target());
            end
            if (clr || flush) exp_out = 72'd0;
            else if (!stall)  exp_out = model_out();
            tick();
            n_cmp++;
            if (out !== exp_out) begin n_err++; $display("FAIL rand_out[%0d]: got %h expected %h", i, out, exp_out); end
        end
        clr = 1'b0; flush = 1'b0; stall = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clr = 1'b1; stall = 1'b0; flush = 1'b0;
        clear_fields();
        test_reset();
        test_sub();
        test_forwarding();
        test_branch();
        test_jump_stall();
        test_priority();
        test_bubble();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 clk  in  1  rising-edge clock; only clock.
REQ-002 clr  in  1  reset, synchronous, active-high.
REQ-003 in  in  163  packed ID/EXE bus: [0]RegWrite [1]MemToReg [2]MemWrite [3]BranchEq [4]Jump [5]ALUSrc [6]RegDst [9:7]ALUc [14:10]Rt [19:15]Rd [35:20]imm [67:36]qa [99:68]qb [131:100]pc4 [157:132]adr [162:158]Rs.
REQ-004 stall  in  1  hold EXE/MEM register contents.
REQ-005 flush  in  1  load bubble (all zero) into EXE/MEM register.
REQ-006 mem_regwrite, mem_rd[4:0], mem_alu[31:0]  in  MEM-stage forwarding source.
REQ-007 wb_regwrite, wb_rd[4:0], wb_data[31:0]  in  WB-stage forwarding source.
REQ-008 out  out  72  EXE/MEM bus: [0]RegWrite [1]MemToReg [2]MemWrite [7:3]WriteReg [39:8]ALU result [71:40]store data.
REQ-009 redirect  out  1  combinational: branch/jump taken this cycle.
REQ-010 target  out  32  combinational redirect PC.

Function
REQ-011 Operand A: mem_alu if mem_regwrite && mem_rd!=0 && mem_rd==Rs; else wb_data if wb_regwrite && wb_rd!=0 && wb_rd==Rs; else qa.
REQ-012 Operand Bf: same rule against Rt, default qb; MEM priority over WB.
REQ-013 simm = sign-extend(imm) to 32 bits; ALU B = ALUSrc ? simm : Bf.
REQ-014 ALUc: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 signed A<B ? 1 : 0, 110 B<<16, 111 ~(A|B); add/sub wrap modulo 2^32, no overflow trap.
REQ-015 WriteReg = RegDst ? Rd : Rt.
REQ-016 Branch taken when BranchEq && A==Bf (forwarded values, independent of ALUSrc).
REQ-017 redirect = (branch taken || Jump) && !stall && !clr.
REQ-018 target = Jump ? {pc4[31:28], adr, 2'b00} : pc4 + (simm<<2); Jump wins if Jump and BranchEq both set.
REQ-019 target = 0 when redirect = 0.
REQ-020 Rising edge, priority clr > flush > stall > load: clr or flush -> out = 0; stall -> out unchanged; else out <= {Bf, ALU result, WriteReg, MemWrite, MemToReg, RegWrite}.
REQ-021 Latency: one cycle from in to out.
REQ-022 RegWrite with WriteReg = 0 is passed through unchanged; downstream discards.
REQ-023 in = 0 (bubble) yields out = 0 on the next load and redirect = 0.
REQ-024 Forwarding mux and redirect logic purely combinational; no cross-cycle state other than out.

Reset
REQ-025 clr sampled only at rising clk; asserted -> out = 0 next edge, regardless of stall/flush/in.
REQ-026 While clr high: redirect = 0, target = 0.
REQ-027 Clr released mid-stream: first non-reset edge loads current in normally.

Verification
REQ-028 qa=5, qb=3, ALUc=001, ALUSrc=0, RegDst=1, Rd=7, RegWrite=1 -> next edge out[39:8]=2, out[7:3]=7, out[0]=1.
REQ-029 Rs=4, mem_regwrite=1, mem_rd=4, mem_alu=0x10, wb_regwrite=1, wb_rd=4, wb_data=0x20, qa=1, imm=1, ALUSrc=1, ALUc=000 -> ALU result 0x11 (MEM wins); repeat with mem_rd=0 and Rs=0 -> result 2 (qa=1, no forwarding from $0).
REQ-030 BranchEq=1, qa=qb=9, pc4=0x100, imm=0xFFFF -> redirect=1, target=0xFC; qb=8 -> redirect=0, target=0.
REQ-031 Jump=1, pc4=0xA0000004, adr=0x0000010 -> target=0xA0000040; with stall=1 -> redirect=0 and out held over 3 cycles.
REQ-032 clr, flush, stall all high with valid in -> out=0; then flush only -> out=0; then all low -> out loads in.
